// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor. The operand is split into
// NSEG = WIDTH/SEG_W segments; segment k is resolved in stage k from the
// carry registered by stage k-1. Each stage carries forward only the
// operand bits it has not yet consumed and the sum bits resolved so far.
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NSEG = WIDTH / SEG_W;
  localparam int MSB  = SEG_W - 1;

  // One segment built from 4-bit lookahead groups; returns {carry_out, sum}.
  function automatic logic [SEG_W:0] cla_seg(input logic [SEG_W-1:0] a,
                                             input logic [SEG_W-1:0] b,
                                             input logic             ci);
    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] p;
    logic [SEG_W:0]   c;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SEG_W; i += 4) begin
      c[i+1] = g[i] | (p[i] & c[i]);
      c[i+2] = g[i+1] | (p[i+1] & g[i]) | (p[i+1] & p[i] & c[i]);
      c[i+3] = g[i+2] | (p[i+2] & g[i+1]) | (p[i+2] & p[i+1] & g[i])
             | (p[i+2] & p[i+1] & p[i] & c[i]);
      c[i+4] = g[i+3] | (p[i+3] & g[i+2]) | (p[i+3] & p[i+2] & g[i+1])
             | (p[i+3] & p[i+2] & p[i+1] & g[i])
             | (p[i+3] & p[i+2] & p[i+1] & p[i] & c[i]);
    end
    return {c[SEG_W], p ^ c[SEG_W-1:0]};
  endfunction

  // Subtraction is A + ~B + 1; the inversion happens once at the input.
  logic [WIDTH-1:0] b_x;
  assign b_x = in_sub ? ~in_b : in_b;

  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    localparam int SRC_W = WIDTH - SEG_W * k;
    localparam int SUM_W = SEG_W * (k + 1);
    localparam bit LAST  = (k == NSEG - 1);

    logic [SRC_W-1:0] src_a;
    logic [SRC_W-1:0] src_b;
    logic             ci;
    logic             up_vld;
    logic             nxt_load;
    logic             load;
    logic [SEG_W:0]   res;
    logic [SUM_W-1:0] nxt_sum;
    logic [SUM_W-1:0] sum;
    logic             vld;
    logic             cy;

    if (k == 0) begin : g_src
      assign src_a   = in_a;
      assign src_b   = b_x;
      assign ci      = in_sub | in_cin;
      assign up_vld  = in_valid;
      assign nxt_sum = res[SEG_W-1:0];
    end else begin : g_src
      assign src_a   = g_stg[k-1].g_rem.rem_a;
      assign src_b   = g_stg[k-1].g_rem.rem_b;
      assign ci      = g_stg[k-1].cy;
      assign up_vld  = g_stg[k-1].vld;
      assign nxt_sum = {res[SEG_W-1:0], g_stg[k-1].sum};
    end

    // Ready ripples back-to-front so bubbles collapse within one cycle.
    if (LAST) begin : g_nxt
      assign nxt_load = out_ready;
    end else begin : g_nxt
      assign nxt_load = g_stg[k+1].load;
    end

    assign load = ~vld | nxt_load;
    assign res  = cla_seg(src_a[SEG_W-1:0], src_b[SEG_W-1:0], ci);

    // Stage occupancy: follows upstream valid whenever the stage loads.
    always_ff @(posedge clk) begin
      if (!rst_n)    vld <= 1'b0;
      else if (load) vld <= up_vld;
    end

    // Stage data: only the last stage is cleared, since it drives the outputs.
    always_ff @(posedge clk) begin
      if (LAST && !rst_n) begin
        cy  <= 1'b0;
        sum <= '0;
      end else if (load && up_vld) begin
        cy  <= res[SEG_W];
        sum <= nxt_sum;
      end
    end

    if (!LAST) begin : g_rem
      logic [SRC_W-SEG_W-1:0] rem_a;
      logic [SRC_W-SEG_W-1:0] rem_b;
      // Operand bits still waiting for their segment's stage.
      always_ff @(posedge clk) begin
        if (load && up_vld) begin
          rem_a <= src_a[SRC_W-1:SEG_W];
          rem_b <= src_b[SRC_W-1:SEG_W];
        end
      end
    end
  end

  // Carry into the MSB is recovered as a ^ b ^ sum at the top bit.
  logic ovf_nxt;
  logic zero_nxt;
  logic ovf_q;
  logic zero_q;

  assign ovf_nxt  = g_stg[NSEG-1].res[SEG_W]
                  ^ (g_stg[NSEG-1].src_a[MSB] ^ g_stg[NSEG-1].src_b[MSB]
                     ^ g_stg[NSEG-1].res[MSB]);
  assign zero_nxt = (g_stg[NSEG-1].nxt_sum == '0);

  // Status flags registered alongside the last stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (g_stg[NSEG-1].load && g_stg[NSEG-1].up_vld) begin
      ovf_q  <= ovf_nxt;
      zero_q <= zero_nxt;
    end
  end

  assign in_ready  = g_stg[0].load;
  assign out_valid = g_stg[NSEG-1].vld;
  assign out_sum   = g_stg[NSEG-1].sum;
  assign out_cout  = g_stg[NSEG-1].cy;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule
